// File: rtl/uart_pkg.sv
// Shared USART definitions: receive/transmit FSM states and frame-format defaults.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO; a push into a full FIFO without a same-cycle pop is dropped
// and flagged with a one-cycle overrun pulse.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overrun
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overrun_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign overrun = overrun_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overrun_q <= push && full && !do_pop;
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// USART receive engine: 2-FF synchronizer, oversampled tick generator, 3-sample majority vote,
// frame FSM with parity/framing checks, and a receive FIFO on a valid/ready stream.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 io_clk,
    input  logic                 io_rstn,
    input  logic                 io_rxd,
    input  logic [DIV_WIDTH-1:0] io_clkDiv,
    input  logic                 io_parityEn,
    input  logic                 io_parityOdd,
    output logic                 io_data_valid,
    input  logic                 io_data_ready,
    output logic [DATA_BITS-1:0] io_data_payload,
    output logic                 io_frameErr,
    output logic                 io_parityErr,
    output logic                 io_overrun,
    output logic                 io_busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    uart_state_t          state;
    uart_state_t          state_nxt;
    logic                 sync1;
    logic                 rxd_s;
    logic                 rxd_prev;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic [1:0]           samp;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 perr;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 start_det;
    logic                 tick;
    logic                 vote;
    logic                 at_vote;
    logic                 at_wrap;
    logic                 decide;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign start_det = (state == ST_IDLE) && !rxd_s && rxd_prev;
    assign tick      = (state != ST_IDLE) && (div_cnt == io_clkDiv);
    // Third sample is the live synchronized input; the first two were captured on earlier ticks.
    assign vote      = maj3(samp[0], samp[1], rxd_s);
    assign at_vote   = tick && (scnt == S_V2);
    assign at_wrap   = tick && (scnt == S_LAST);
    assign decide    = (state == ST_STOP) && at_vote;
    assign push      = decide && vote && !perr;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_det) state_nxt = ST_START;
            ST_START: begin
                if (at_vote && vote) state_nxt = ST_IDLE;
                else if (at_wrap)    state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (at_wrap && (bcnt == BW'(DATA_BITS - 1)))
                    state_nxt = par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (at_wrap) state_nxt = ST_STOP;
            ST_STOP:   if (at_vote) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge io_clk) begin
        if (!io_rstn) begin
            sync1        <= 1'b1;
            rxd_s        <= 1'b1;
            rxd_prev     <= 1'b1;
            state        <= ST_IDLE;
            div_cnt      <= '0;
            scnt         <= '0;
            bcnt         <= '0;
            shreg        <= '0;
            samp         <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            perr         <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            sync1        <= io_rxd;
            rxd_s        <= sync1;
            rxd_prev     <= rxd_s;
            state        <= state_nxt;
            frame_err_q  <= decide && !vote;
            parity_err_q <= decide && vote && perr;
            if (start_det) begin
                div_cnt   <= '0;
                scnt      <= '0;
                bcnt      <= '0;
                perr      <= 1'b0;
                par_en_q  <= io_parityEn;
                par_odd_q <= io_parityOdd;
            end else if (tick) begin
                div_cnt <= '0;
                scnt    <= (scnt == S_LAST) ? '0 : scnt + 1'b1;
                if (scnt == S_V0) samp[0] <= rxd_s;
                if (scnt == S_V1) samp[1] <= rxd_s;
                if ((state == ST_DATA) && (scnt == S_V2))
                    shreg <= {vote, shreg[DATA_BITS-1:1]};
                if ((state == ST_DATA) && (scnt == S_LAST))
                    bcnt <= bcnt + 1'b1;
                if ((state == ST_PARITY) && (scnt == S_V2))
                    perr <= vote ^ (^shreg) ^ par_odd_q;
            end else if (state != ST_IDLE) begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_BITS)
    ) u_fifo (
        .clk      (io_clk),
        .rstn     (io_rstn),
        .push     (push),
        .push_data(shreg),
        .pop      (io_data_valid && io_data_ready),
        .head     (io_data_payload),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overrun  (io_overrun)
    );

    assign io_data_valid = !fifo_empty;
    assign io_frameErr   = frame_err_q;
    assign io_parityErr  = parity_err_q;
    assign io_busy       = (state != ST_IDLE);

endmodule
